// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential radix-2 restoring divider. Divides a 2*WIDTH-bit dividend by a
// WIDTH-bit divisor and produces one quotient bit per clock.
//
// Flow: IDLE/DONE -> LOAD -> ITER (WIDTH cycles) [-> FIX] -> DONE.
// LOAD handles the early exits (zero divisor, quotient overflow) in one cycle.
//
// Optional build macro: DIV_SIGNED_EN
//   Undefined : unsigned operands; FIX is never entered.
//   Defined   : two's-complement operands; LOAD divides magnitudes and FIX
//               applies the signs (truncation toward zero).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   start        in   operation request, sampled only in IDLE or DONE
//   A            in   2*WIDTH-bit dividend, captured on the accept edge
//   B            in   WIDTH-bit divisor, captured on the accept edge
//   Q            out  quotient
//   R            out  remainder
//   Finish       out  result valid, held until the next accept
//   busy         out  high in LOAD, ITER and FIX
//   div_zero     out  divisor was zero
//   overflow     out  quotient does not fit in WIDTH bits
//   count        out  cycles of the current/last operation incl. load cycle
//   dbg_state_o  out  current FSM state (debug)
//
// Handshake: start is a level request. It is accepted on any rising edge where
// the FSM sits in IDLE or DONE; while busy it is ignored. Finish stays high
// in DONE and drops on the edge after a new accept.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 Finish,
    output logic                 busy,
    output logic                 div_zero,
    output logic                 overflow,
    output logic [2*WIDTH-1:0]   count,
    output logic [2:0]           dbg_state_o
);

    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH:0]       p_q, p_d;      // partial remainder, one guard bit
    logic [WIDTH-1:0]     s_q, s_d;      // dividend low half / quotient bits
    logic [IW-1:0]        iter_q, iter_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic                 finish_q, finish_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   count_q, count_d;

    // One restoring step: shift {P,S} left, trial-subtract the divisor.
    logic [WIDTH:0]       p_sh;
    logic [WIDTH-1:0]     s_sh;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH:0]       p_step;
    logic [WIDTH-1:0]     s_step;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [2*WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 q_neg;
`endif

    always_comb begin
        {p_sh, s_sh} = {p_q[WIDTH-1:0], s_q, 1'b0};
        trial        = {1'b0, p_sh} - {2'b00, b_q};
        if (!trial[WIDTH+1]) begin
            p_step = trial[WIDTH:0];
            s_step = {s_sh[WIDTH-1:1], 1'b1};
        end else begin
            p_step = p_sh;
            s_step = s_sh;
        end
    end

`ifdef DIV_SIGNED_EN
    always_comb begin
        a_mag = a_q[2*WIDTH-1] ? -a_q : a_q;
        b_mag = b_q[WIDTH-1]   ? -b_q : b_q;
        q_neg = sa_q ^ sb_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        s_d      = s_q;
        iter_d   = iter_q;
        q_d      = q_q;
        r_d      = r_q;
        finish_d = finish_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
`ifdef DIV_SIGNED_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    a_d      = A;
                    b_d      = B;
                    finish_d = 1'b0;
                    dz_d     = 1'b0;
                    ovf_d    = 1'b0;
                    count_d  = {{(2*WIDTH-1){1'b0}}, 1'b1};
                end
            end

            S_LOAD: begin
`ifdef DIV_SIGNED_EN
                sa_d = a_q[2*WIDTH-1];
                sb_d = b_q[WIDTH-1];
                if (b_mag == '0) begin
                    dz_d     = 1'b1;
                    q_d      = '1;
                    r_d      = a_q[WIDTH-1:0];
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else if (a_mag[2*WIDTH-1:WIDTH] >= b_mag) begin
                    ovf_d    = 1'b1;
                    q_d      = '1;
                    r_d      = '0;
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    b_d     = b_mag;
                    p_d     = {1'b0, a_mag[2*WIDTH-1:WIDTH]};
                    s_d     = a_mag[WIDTH-1:0];
                    iter_d  = IW'(WIDTH);
                    state_d = S_ITER;
                end
`else
                if (b_q == '0) begin
                    dz_d     = 1'b1;
                    q_d      = '1;
                    r_d      = a_q[WIDTH-1:0];
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else if (a_q[2*WIDTH-1:WIDTH] >= b_q) begin
                    ovf_d    = 1'b1;
                    q_d      = '1;
                    r_d      = '0;
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    p_d     = {1'b0, a_q[2*WIDTH-1:WIDTH]};
                    s_d     = a_q[WIDTH-1:0];
                    iter_d  = IW'(WIDTH);
                    state_d = S_ITER;
                end
`endif
            end

            S_ITER: begin
                p_d     = p_step;
                s_d     = s_step;
                iter_d  = iter_q - 1'b1;
                count_d = count_q + 1'b1;
                if (iter_q == IW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    q_d      = s_step;
                    r_d      = p_step[WIDTH-1:0];
                    finish_d = 1'b1;
                    state_d  = S_DONE;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            S_FIX: begin
                count_d  = count_q + 1'b1;
                finish_d = 1'b1;
                state_d  = S_DONE;
                // Negative quotients may reach -2^(WIDTH-1); positive ones stop one short.
                if ((q_neg && (s_q > HALF)) || (!q_neg && (s_q >= HALF))) begin
                    ovf_d = 1'b1;
                    q_d   = '1;
                    r_d   = '0;
                end else begin
                    q_d = q_neg ? -s_q : s_q;
                    r_d = sa_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            s_q      <= '0;
            iter_q   <= '0;
            q_q      <= '0;
            r_q      <= '0;
            finish_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
`ifdef DIV_SIGNED_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            s_q      <= s_d;
            iter_q   <= iter_d;
            q_q      <= q_d;
            r_q      <= r_d;
            finish_q <= finish_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
`ifdef DIV_SIGNED_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
`endif
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign Finish      = finish_q;
    assign busy        = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
    assign div_zero    = dz_q;
    assign overflow    = ovf_q;
    assign count       = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider (WIDTH=8). A reference model computes the expected
// result of each operation when it is driven; the expectation is queued and
// compared when Finish rises. Build with DIV_SIGNED_EN defined to exercise
// the signed variant.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W  = 8;
    localparam int EW = 2 + 2 * W + 2 * W;   // {dz, ovf, Q, R, count}

    logic              clk;
    logic              reset;
    logic              start;
    logic [2*W-1:0]    A;
    logic [W-1:0]      B;
    logic [W-1:0]      Q;
    logic [W-1:0]      R;
    logic              Finish;
    logic              busy;
    logic              div_zero;
    logic              overflow;
    logic [2*W-1:0]    count;
    logic [2:0]        dbg_state_o;

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     last_exp;
    int                n_total;
    int                n_bad;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .Finish      (Finish),
        .busy        (busy),
        .div_zero    (div_zero),
        .overflow    (overflow),
        .count       (count),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: {div_zero, overflow, Q, R, count}
    function automatic logic [EW-1:0] model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        logic           dz, ov;
        logic [W-1:0]   q, r;
        logic [2*W-1:0] c;
        logic [2*W-1:0] ma, qm, rm;
        logic [W-1:0]   mb;
        logic           neg;
        dz = 1'b0; ov = 1'b0; q = '0; r = '0; c = 16'd1;
`ifdef DIV_SIGNED_EN
        ma  = a[2*W-1] ? -a : a;
        mb  = b[W-1] ? -b : b;
        neg = a[2*W-1] ^ b[W-1];
`else
        ma  = a;
        mb  = b;
        neg = 1'b0;
`endif
        if (mb == 0) begin
            dz = 1'b1; q = '1; r = a[W-1:0];
        end else if (ma[2*W-1:W] >= mb) begin
            ov = 1'b1; q = '1; r = '0;
        end else begin
            qm = ma / {8'h00, mb};
            rm = ma % {8'h00, mb};
`ifdef DIV_SIGNED_EN
            c = 16'(W + 2);
            if ((neg && qm > 16'd128) || (!neg && qm > 16'd127)) begin
                ov = 1'b1; q = '1; r = '0;
            end else begin
                q = neg ? -qm[W-1:0] : qm[W-1:0];
                r = a[2*W-1] ? -rm[W-1:0] : rm[W-1:0];
            end
`else
            c = 16'(W + 1);
            q = qm[W-1:0];
            r = rm[W-1:0];
`endif
        end
        return {dz, ov, q, r, c};
    endfunction

    task automatic compare_result(input int lat, input int busy_n);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("div_zero",    32'(div_zero), 32'(e[EW-1]));
            check("overflow",    32'(overflow), 32'(e[EW-2]));
            check("q",           32'(Q),        32'(e[4*W-1:3*W]));
            check("r",           32'(R),        32'(e[3*W-1:2*W]));
            check("count",       32'(count),    32'(e[2*W-1:0]));
            check("latency",     32'(lat),      32'(e[2*W-1:0]));
            check("busy_cycles", 32'(busy_n),   32'(e[2*W-1:0]));
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at a negedge with Finish high (or timeout).
    // poke_at > 0 re-asserts start with fresh operands that many cycles in.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input int poke_at);
        int lat;
        int busy_n;
        A = a; B = b; start = 1'b1;
        last_exp = model(a, b);
        exp_q.push_back(last_exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom);
        B = 8'($urandom);
        check("fin_clr", 32'(Finish), 32'd0);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!Finish && lat < 40) begin
            if (poke_at > 0 && lat == poke_at) begin
                start = 1'b1;
                A = 16'($urandom);
                B = 8'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
        end
        check("done", 32'(Finish), 32'd1);
        compare_result(lat, busy_n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] hi;
        logic [W-1:0] bb;
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        start = 1'b1;
        A = '0;
        B = '0;

        // Held in reset well past when a result would appear.
        repeat (12) @(negedge clk);
        check("rst_q",      32'(Q),           32'd0);
        check("rst_r",      32'(R),           32'd0);
        check("rst_finish", 32'(Finish),      32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_dz",     32'(div_zero),    32'd0);
        check("rst_ovf",    32'(overflow),    32'd0);
        check("rst_count",  32'(count),       32'd0);
        check("rst_state",  32'(dbg_state_o), 32'd0);
        reset = 1'b0;

        run_op(16'd0, 8'd0, 0);          // zero divisor
        run_op(16'd1000, 8'd7, 0);       // 142 r 6
        run_op(16'h0800, 8'd8, 0);       // overflow boundary
        run_op(16'h07FF, 8'd8, 0);       // largest fitting quotient

        // Results hold in DONE without start.
        repeat (3) @(negedge clk);
        check("hold_finish", 32'(Finish), 32'd1);
        check("hold_q",      32'(Q),      32'(last_exp[4*W-1:3*W]));
        check("hold_r",      32'(R),      32'(last_exp[3*W-1:2*W]));
        check("hold_count",  32'(count),  32'(last_exp[2*W-1:0]));

        // Asynchronous abort mid-operation.
        A = 16'd1000; B = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_q",      32'(Q),           32'd0);
        check("abort_r",      32'(R),           32'd0);
        check("abort_finish", 32'(Finish),      32'd0);
        check("abort_busy",   32'(busy),        32'd0);
        check("abort_count",  32'(count),       32'd0);
        check("abort_state",  32'(dbg_state_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(16'd255, 8'd16, 0);       // 15 r 15
        run_op(16'h1234, 8'h77, 3);      // start while busy ignored

`ifdef DIV_SIGNED_EN
        run_op(16'hFF9C, 8'd7, 0);       // -100 / 7
        run_op(16'hFC00, 8'd8, 0);       // -1024 / 8 = -128
        run_op(16'h0400, 8'd8, 0);       // 1024 / 8 overflows
`endif

        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 3) begin
                bb = 8'($urandom_range(0, 3));
                run_op(16'($urandom), bb, 0);
            end else begin
                bb = 8'($urandom_range(1, 255));
                hi = 8'($urandom_range(0, int'(bb) - 1));
                run_op({hi, 8'($urandom)}, bb, (i % 2 == 0) ? 2 : 0);
            end
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
